// File: rtl/mips_burst_mem.sv
`default_nettype none
// ============================================================================
// Module   : mips_burst_mem
// Brief    : Unified MIPS instruction/data memory. Word-organised, little-endian
//            byte lanes, mapped at BASE_ADDR. Single byte/half/word accesses
//            with one-cycle read latency, plus 4/8/16-word bursts driven by a
//            two-state burst FSM. Rejected requests raise a one-cycle err.
//            Optional macro MEM_SIGNED_LOAD_EN adds a load_signed input that
//            sign-extends byte/half reads.
// Revision : 1.0 - initial release
// ============================================================================
module mips_burst_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h80020000,
    parameter int unsigned DEPTH_BYTES = 1048576,
    parameter              MEM_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic [2:0]  access_size,
    input  logic        rd_wr,
    input  logic        enable,
`ifdef MEM_SIGNED_LOAD_EN
    input  logic        load_signed,
`endif
    output logic [31:0] data_out,
    output logic        rd_valid,
    output logic        busy,
    output logic        err
);

    localparam int unsigned c_WORDS   = DEPTH_BYTES / 4;
    localparam int          c_IDX_W   = $clog2(c_WORDS);

    localparam logic [2:0]  c_SZ_BYTE = 3'd0;
    localparam logic [2:0]  c_SZ_HALF = 3'd1;
    localparam logic [2:0]  c_SZ_B4   = 3'd3;
    localparam logic [2:0]  c_SZ_B8   = 3'd4;
    localparam logic [2:0]  c_SZ_B16  = 3'd5;

    localparam logic [0:0]  c_ST_IDLE  = 1'b0;
    localparam logic [0:0]  c_ST_BURST = 1'b1;

    logic [31:0]        r_mem [0:c_WORDS-1];

    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_base_idx;
    logic [3:0]         r_beat;
    logic [3:0]         r_cnt;
    logic               r_rd;
    logic [31:0]        r_data_out;
    logic               r_rd_valid;
    logic               r_busy;
    logic               r_err;

    logic [31:0]        w_off;
    logic               w_in_range;
    logic [c_IDX_W-1:0] w_req_idx;
    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_lane;
    logic               w_is_burst;
    logic               w_reject;
    logic [3:0]         w_beats_m1;
    logic               w_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rword;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_rdata;
    logic               w_signed;

`ifdef MEM_SIGNED_LOAD_EN
    assign w_signed = load_signed;
`else
    assign w_signed = 1'b0;
`endif

    // Address decode: offset from base, range check, word index (wraps because
    // the depth is a power of two) and byte lane.
    assign w_off      = addr - BASE_ADDR;
    assign w_in_range = (w_off < 32'(DEPTH_BYTES));
    assign w_req_idx  = w_off[c_IDX_W+1:2];
    assign w_lane     = addr[1:0];
    assign w_is_burst = (access_size == c_SZ_B4) || (access_size == c_SZ_B8) ||
                        (access_size == c_SZ_B16);
    assign w_reject   = (access_size[2:1] == 2'b11) || !w_in_range ||
                        ((access_size == c_SZ_HALF) && addr[0]) ||
                        (w_is_burst && (addr[1:0] != 2'b00));

    // Beat index during a burst: base plus beat number, wrapping over the array.
    assign w_idx   = (r_state == c_ST_BURST) ? (r_base_idx + c_IDX_W'(r_beat)) : w_req_idx;
    assign w_rword = r_mem[w_idx];
    assign w_byte  = w_rword[{w_lane, 3'b000} +: 8];
    assign w_half  = addr[1] ? w_rword[31:16] : w_rword[15:0];

    // Beat count minus one for the requested burst length.
    always_comb begin
        w_beats_m1 = 4'd3;
        case (access_size)
            c_SZ_B8:  w_beats_m1 = 4'd7;
            c_SZ_B16: w_beats_m1 = 4'd15;
            default:  w_beats_m1 = 4'd3;
        endcase
    end

    // Lane enables and lane-replicated write data; bursts always write full words.
    always_comb begin
        w_be    = 4'hF;
        w_wdata = data_in;
        if (r_state == c_ST_IDLE) begin
            case (access_size)
                c_SZ_BYTE: begin
                    w_be    = 4'b0001 << w_lane;
                    w_wdata = {4{data_in[7:0]}};
                end
                c_SZ_HALF: begin
                    w_be    = addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{data_in[15:0]}};
                end
                default: begin
                    w_be    = 4'hF;
                    w_wdata = data_in;
                end
            endcase
        end
    end

    // Read data formatting: byte/half land in the LSBs, extended per load_signed.
    always_comb begin
        w_rdata = w_rword;
        if (r_state == c_ST_IDLE) begin
            case (access_size)
                c_SZ_BYTE: w_rdata = {{24{w_signed & w_byte[7]}}, w_byte};
                c_SZ_HALF: w_rdata = {{16{w_signed & w_half[15]}}, w_half};
                default:   w_rdata = w_rword;
            endcase
        end
    end

    // Reset suppresses any write in the same cycle, including a pending burst beat.
    assign w_we = !rst &&
                  (((r_state == c_ST_BURST) && !r_rd) ||
                   ((r_state == c_ST_IDLE) && enable && !w_reject && !rd_wr));

    // Storage array: lane-masked writes, no reset of contents.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Request acceptance, burst sequencing and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_base_idx <= '0;
            r_beat     <= 4'd0;
            r_cnt      <= 4'd0;
            r_rd       <= 1'b0;
            r_data_out <= 32'd0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                if (enable) begin
                    if (w_reject) begin
                        r_err <= 1'b1;
                    end else begin
                        if (rd_wr) begin
                            r_data_out <= w_rdata;
                            r_rd_valid <= 1'b1;
                        end
                        // Beat 0 executes now; remaining beats follow in BURST.
                        if (w_is_burst) begin
                            r_base_idx <= w_req_idx;
                            r_rd       <= rd_wr;
                            r_beat     <= 4'd1;
                            r_cnt      <= w_beats_m1;
                            r_busy     <= 1'b1;
                            r_state    <= c_ST_BURST;
                        end
                    end
                end
            end else begin
                if (r_rd) begin
                    r_data_out <= w_rdata;
                    r_rd_valid <= 1'b1;
                end
                r_beat <= r_beat + 4'd1;
                r_cnt  <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            end
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_burst_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_burst_mem
// Brief    : Self-checking bench for mips_burst_mem. A byte-addressed reference
//            memory predicts every read, reject and busy window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_burst_mem;

    localparam logic [31:0] c_BASE  = 32'h80020000;
    localparam int unsigned c_DEPTH = 4096;
`ifdef MEM_SIGNED_LOAD_EN
    localparam bit c_SIGNED_EN = 1'b1;
`else
    localparam bit c_SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [2:0]  access_size;
    logic        rd_wr;
    logic        enable;
    logic        load_signed;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        busy;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_mem [0:c_DEPTH-1];
    logic [31:0] m_last;
    logic [31:0] bdata [16];

    mips_burst_mem #(
        .BASE_ADDR  (c_BASE),
        .DEPTH_BYTES(c_DEPTH),
        .MEM_FILE   ("")
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data_in    (data_in),
        .access_size(access_size),
        .rd_wr      (rd_wr),
        .enable     (enable),
`ifdef MEM_SIGNED_LOAD_EN
        .load_signed(load_signed),
`endif
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_reject(input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] off;
        off = a - c_BASE;
        if (sz >= 3'd6) return 1'b1;
        if (off >= c_DEPTH) return 1'b1;
        if (sz == 3'd1 && a[0]) return 1'b1;
        if (sz >= 3'd3 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_word(input int unsigned boff);
        int unsigned o;
        o = boff % c_DEPTH;
        return {m_mem[o+3], m_mem[o+2], m_mem[o+1], m_mem[o]};
    endfunction

    function automatic void m_set_word(input int unsigned boff, input logic [31:0] d);
        int unsigned o;
        o = boff % c_DEPTH;
        for (int i = 0; i < 4; i++) m_mem[o+i] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [2:0] sz, input logic ls);
        int unsigned off;
        logic [7:0]  b;
        logic [15:0] h;
        off = a - c_BASE;
        if (sz == 3'd0) begin
            b = m_mem[off];
            return (ls && c_SIGNED_EN) ? {{24{b[7]}}, b} : {24'd0, b};
        end
        if (sz == 3'd1) begin
            h = {m_mem[off+1], m_mem[off]};
            return (ls && c_SIGNED_EN) ? {{16{h[15]}}, h} : {16'd0, h};
        end
        return m_word(off & ~32'd3);
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int unsigned off;
        off = a - c_BASE;
        if (sz == 3'd0) m_mem[off] = d[7:0];
        else if (sz == 3'd1) begin
            m_mem[off]   = d[7:0];
            m_mem[off+1] = d[15:8];
        end else m_set_word(off & ~32'd3, d);
    endfunction

    // ---------------- transactions ----------------
    task automatic single(input logic [31:0] a, input logic [2:0] sz, input logic rw,
                          input logic [31:0] d, input logic ls, input string tag);
        bit          rej;
        bit          rd;
        logic [31:0] exp;
        rej = m_reject(a, sz);
        rd  = !rej && rw;
        exp = rd ? m_read(a, sz, ls) : m_last;
        addr = a; access_size = sz; rd_wr = rw; data_in = d; load_signed = ls; enable = 1'b1;
        tick();
        enable = 1'b0;
        if (!rej && !rw) m_write(a, sz, d);
        check({tag, ".err"},   {31'd0, err},      {31'd0, rej});
        check({tag, ".valid"}, {31'd0, rd_valid}, {31'd0, rd});
        check({tag, ".data"},  data_out,          exp);
        check({tag, ".busy"},  {31'd0, busy},     32'd0);
        m_last = exp;
    endtask

    // Burst using bdata[] as write data; inputs are scrambled while busy.
    task automatic burst(input logic [31:0] a, input logic [2:0] sz, input logic rw, input string tag);
        bit          rej;
        int          n;
        int unsigned off;
        logic [31:0] exp [16];
        rej = m_reject(a, sz);
        n   = 4 << (int'(sz) - 3);
        off = a - c_BASE;
        for (int k = 0; k < 16; k++) exp[k] = m_word(off + 4*k);
        addr = a; access_size = sz; rd_wr = rw; data_in = bdata[0]; enable = 1'b1;
        tick();
        if (rej) begin
            enable = 1'b0;
            check({tag, ".err"},   {31'd0, err},      32'd1);
            check({tag, ".valid"}, {31'd0, rd_valid}, 32'd0);
            check({tag, ".busy"},  {31'd0, busy},     32'd0);
            return;
        end
        if (!rw) m_set_word(off, bdata[0]);
        for (int k = 1; k < n; k++) begin
            check({tag, ".busy"},  {31'd0, busy},     32'd1);
            check({tag, ".err"},   {31'd0, err},      32'd0);
            check({tag, ".valid"}, {31'd0, rd_valid}, {31'd0, rw});
            check({tag, ".data"},  data_out,          rw ? exp[k-1] : m_last);
            data_in     = bdata[k];
            enable      = 1'($urandom);
            addr        = $urandom;
            access_size = 3'($urandom);
            rd_wr       = 1'($urandom);
            tick();
            if (!rw) m_set_word(off + 4*k, bdata[k]);
        end
        enable = 1'b0;
        check({tag, ".end_busy"},  {31'd0, busy},     32'd0);
        check({tag, ".end_valid"}, {31'd0, rd_valid}, {31'd0, rw});
        check({tag, ".end_data"},  data_out,          rw ? exp[n-1] : m_last);
        if (rw) m_last = exp[n-1];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".dout"},  data_out,          32'd0);
        check({tag, ".valid"}, {31'd0, rd_valid}, 32'd0);
        check({tag, ".busy"},  {31'd0, busy},     32'd0);
        check({tag, ".err"},   {31'd0, err},      32'd0);
        m_last = 32'd0;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int unsigned off;

        rst = 1'b1; enable = 1'b0; addr = 32'd0; data_in = 32'd0;
        access_size = 3'd2; rd_wr = 1'b1; load_signed = 1'b0;
        m_last = 32'd0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Fill the whole array so every later read has a known expectation.
        for (int i = 0; i < c_DEPTH / 64; i++) begin
            for (int k = 0; k < 16; k++) bdata[k] = $urandom;
            burst(c_BASE + 32'(64 * i), 3'd5, 1'b0, "fill");
        end

        // rst and enable together: request dropped.
        rst = 1'b1; enable = 1'b1; addr = c_BASE + 32'h100; access_size = 3'd2;
        rd_wr = 1'b0; data_in = 32'hCAFEF00D;
        tick();
        rst = 1'b0; enable = 1'b0;
        check_reset_outputs("rst_en");
        single(c_BASE + 32'h100, 3'd2, 1'b1, 32'd0, 1'b0, "rst_en_rd");

        // Word write then byte read of lane 2.
        single(c_BASE + 32'h10, 3'd2, 1'b0, 32'hDEADBEEF, 1'b0, "tp1_wr");
        single(c_BASE + 32'h12, 3'd0, 1'b1, 32'd0, 1'b0, "tp1_rd");
        check("tp1_lit", data_out, 32'h000000AD);

        // Byte merge, then misaligned half rejected.
        single(c_BASE, 3'd2, 1'b0, 32'h11223344, 1'b0, "tp2_w");
        single(c_BASE + 32'h1, 3'd0, 1'b0, 32'h0000005A, 1'b0, "tp2_b");
        single(c_BASE, 3'd2, 1'b1, 32'd0, 1'b0, "tp2_rd");
        check("tp2_lit", data_out, 32'h11225A44);
        single(c_BASE + 32'h3, 3'd1, 1'b1, 32'd0, 1'b0, "tp2_half_rej");
        single(c_BASE, 3'd2, 1'b1, 32'd0, 1'b0, "tp2_rd2");

        // 8-word write of 0..7 and read back with inputs scrambled while busy.
        for (int k = 0; k < 16; k++) bdata[k] = 32'(k);
        burst(c_BASE + 32'h20, 3'd4, 1'b0, "tp3_w");
        burst(c_BASE + 32'h20, 3'd4, 1'b1, "tp3_r");
        check("tp3_lit", data_out, 32'd7);

        // 4-word read wrapping past the top of the array.
        burst(c_BASE + c_DEPTH - 8, 3'd3, 1'b1, "tp4_wrap");

        // Reset during beat 3 of a 16-word write.
        for (int k = 0; k < 16; k++) bdata[k] = 32'hA5000000 | 32'(k);
        addr = c_BASE + 32'h200; access_size = 3'd5; rd_wr = 1'b0;
        data_in = bdata[0]; enable = 1'b1;
        tick();
        enable = 1'b0;
        m_set_word(32'h200, bdata[0]);
        for (int k = 1; k < 3; k++) begin
            data_in = bdata[k];
            tick();
            m_set_word(32'h200 + 4*k, bdata[k]);
        end
        rst = 1'b1; data_in = bdata[3];
        tick();
        rst = 1'b0;
        check_reset_outputs("tp5_rst");
        single(c_BASE + 32'h20C, 3'd2, 1'b1, 32'd0, 1'b0, "tp5_w3");
        single(c_BASE + 32'h208, 3'd2, 1'b1, 32'd0, 1'b0, "tp5_w2");
        for (int k = 4; k < 16; k++)
            single(c_BASE + 32'h200 + 32'(4*k), 3'd2, 1'b1, 32'd0, 1'b0, "tp5_tail");

        // Byte 0x80 read with and without load_signed.
        single(c_BASE + 32'h301, 3'd0, 1'b0, 32'h00000080, 1'b0, "tp6_w");
        single(c_BASE + 32'h301, 3'd0, 1'b1, 32'd0, 1'b1, "tp6_s1");
        single(c_BASE + 32'h301, 3'd0, 1'b1, 32'd0, 1'b0, "tp6_s0");
        check("tp6_lit", data_out, 32'h00000080);

        // Randomized mix of singles, bursts and illegal requests.
        for (int i = 0; i < 300; i++) begin
            off = $urandom_range(0, c_DEPTH - 1);
            case ($urandom_range(0, 9))
                0:       a = c_BASE - 32'($urandom_range(1, 64));
                1:       a = c_BASE + c_DEPTH + 32'($urandom_range(0, 64));
                default: a = c_BASE + off;
            endcase
            if ($urandom_range(0, 9) < 6) begin
                sz = 3'($urandom_range(0, 2));
                if ($urandom_range(0, 15) == 0) sz = 3'($urandom_range(6, 7));
                single(a, sz, 1'($urandom), $urandom, 1'($urandom), "rnd_single");
            end else begin
                sz = 3'($urandom_range(3, 5));
                if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
                for (int k = 0; k < 16; k++) bdata[k] = $urandom;
                burst(a, sz, 1'($urandom), "rnd_burst");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
